apb_upio_irq: RTL and testbench

APB_UPIO_IRQ -- requirements
Module: apb_upio_irq

---
 rtl/apb_upio_if.sv | 24 ++
 rtl/apb_upio_irq.sv | 135 +++++++++++++
 tb/tb_apb_upio_irq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_upio_if.sv
// APB3 slave-side bus bundle for the UPIO block; signal names follow the AMBA APB naming.
`timescale 1ns/1ps
interface apb_upio_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_upio_irq.sv
// APB-mapped general-purpose pins with set/clear/toggle helpers and per-pin
// level/edge interrupts latched in a write-1-to-clear status register.
`timescale 1ns/1ps
module apb_upio_irq #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_PINS       = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clk_i,
    input  logic                rst_n,
    apb_upio_if.slave           apb,
    input  logic [NUM_PINS-1:0] upio_in_i,
    output logic [NUM_PINS-1:0] upio_out_o,
    output logic [NUM_PINS-1:0] upio_dir_o,
    output logic                int_o
);

    localparam logic [3:0] IDX_DIR    = 4'd0;
    localparam logic [3:0] IDX_OUT    = 4'd1;
    localparam logic [3:0] IDX_IN     = 4'd2;
    localparam logic [3:0] IDX_INTEN  = 4'd3;
    localparam logic [3:0] IDX_TYPE   = 4'd4;
    localparam logic [3:0] IDX_POL    = 4'd5;
    localparam logic [3:0] IDX_STATUS = 4'd6;
    localparam logic [3:0] IDX_SET    = 4'd7;
    localparam logic [3:0] IDX_CLR    = 4'd8;
    localparam logic [3:0] IDX_TOG    = 4'd9;

    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [3:0]                idx;
    logic                      addrErr;
    logic                      access;
    logic                      wrEn;
    logic [NUM_PINS-1:0]       wdata;
    logic                      unusedPwdata;

    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] out_q, out_d;
    logic [NUM_PINS-1:0] inten_q, inten_d;
    logic [NUM_PINS-1:0] type_q, type_d;
    logic [NUM_PINS-1:0] pol_q, pol_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] syncOut;
    logic [NUM_PINS-1:0] evt;
    logic [NUM_PINS-1:0] w1c;
    logic [31:0]         rdata;

    assign addr         = apb.PADDR;
    assign idx          = addr[5:2];
    assign addrErr      = (addr >= APB_ADDR_WIDTH'(32'h28)) || (addr[1:0] != 2'b00);
    assign access       = apb.PSEL & apb.PENABLE;
    assign wrEn         = access & apb.PWRITE & ~addrErr;
    assign wdata        = apb.PWDATA[NUM_PINS-1:0];
    assign unusedPwdata = ^apb.PWDATA;

    assign syncOut = sync_q[SYNC_STAGES-1];

    // Level mode matches POL directly; edge mode compares against last cycle's sample.
    assign evt = (~type_q & ~(syncOut ^ pol_q))
               | ( type_q &  pol_q &  syncOut & ~prev_q)
               | ( type_q & ~pol_q & ~syncOut &  prev_q);

    assign w1c = (wrEn && idx == IDX_STATUS) ? wdata : '0;

    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        inten_d  = inten_q;
        type_d   = type_q;
        pol_d    = pol_q;
        if (wrEn) begin
            case (idx)
                IDX_DIR:   dir_d   = wdata;
                IDX_OUT:   out_d   = wdata;
                IDX_INTEN: inten_d = wdata;
                IDX_TYPE:  type_d  = wdata;
                IDX_POL:   pol_d   = wdata;
                IDX_SET:   out_d   = out_q | wdata;
                IDX_CLR:   out_d   = out_q & ~wdata;
                IDX_TOG:   out_d   = out_q ^ wdata;
                default:   ;
            endcase
        end
        // A new event outranks a simultaneous clear so it is never lost.
        status_d = (status_q & ~w1c) | (evt & inten_q);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dir_q    <= '0;
            out_q    <= '0;
            inten_q  <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            prev_q   <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            inten_q  <= inten_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            prev_q   <= syncOut;
            sync_q[0] <= upio_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            IDX_DIR:    rdata[NUM_PINS-1:0] = dir_q;
            IDX_OUT:    rdata[NUM_PINS-1:0] = out_q;
            IDX_IN:     rdata[NUM_PINS-1:0] = syncOut;
            IDX_INTEN:  rdata[NUM_PINS-1:0] = inten_q;
            IDX_TYPE:   rdata[NUM_PINS-1:0] = type_q;
            IDX_POL:    rdata[NUM_PINS-1:0] = pol_q;
            IDX_STATUS: rdata[NUM_PINS-1:0] = status_q;
            default:    rdata = '0;
        endcase
    end

    assign apb.PRDATA  = (rst_n && apb.PSEL && !addrErr) ? rdata : 32'h0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = rst_n & access & addrErr;

    assign upio_out_o = out_q;
    assign upio_dir_o = dir_q;
    assign int_o      = |(status_q & inten_q);

endmodule

// File: tb/tb_apb_upio_irq.sv
// Directed bench for apb_upio_irq: one task per scenario, expected values hand-computed.
`timescale 1ns/1ps
module tb_apb_upio_irq;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [15:0] pins;
    logic [15:0] outPins, dirPins;
    logic        irq;
    logic [7:0]  pins8, out8, dir8;
    logic        irq8;
    logic [31:0] rd;
    logic        err;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;

    apb_upio_if #(.ADDR_WIDTH(12)) bus  ();
    apb_upio_if #(.ADDR_WIDTH(12)) bus8 ();

    apb_upio_irq #(.APB_ADDR_WIDTH(12), .NUM_PINS(16), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .apb(bus.slave),
        .upio_in_i(pins), .upio_out_o(outPins), .upio_dir_o(dirPins), .int_o(irq)
    );

    apb_upio_irq #(.APB_ADDR_WIDTH(12), .NUM_PINS(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk_i), .rst_n(rst_n), .apb(bus8.slave),
        .upio_in_i(pins8), .upio_out_o(out8), .upio_dir_o(dir8), .int_o(irq8)
    );

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic slvErr);
        @(negedge clk_i);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = data;
        @(negedge clk_i);
        bus.PENABLE = 1'b1;
        #1 slvErr = bus.PSLVERR;
        @(negedge clk_i);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic dummy;
        apb_write(addr, data, dummy);
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic slvErr);
        @(negedge clk_i);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
        @(negedge clk_i);
        bus.PENABLE = 1'b1;
        #1 data = bus.PRDATA; slvErr = bus.PSLVERR;
        @(negedge clk_i);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic apb8_access(input logic write, input logic [11:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata);
        @(negedge clk_i);
        bus8.PSEL = 1'b1; bus8.PENABLE = 1'b0; bus8.PWRITE = write; bus8.PADDR = addr; bus8.PWDATA = data;
        @(negedge clk_i);
        bus8.PENABLE = 1'b1;
        #1 rdata = bus8.PRDATA;
        @(negedge clk_i);
        bus8.PSEL = 1'b0; bus8.PENABLE = 1'b0; bus8.PWRITE = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pins = '0; pins8 = '0;
        bus8.PSEL = 0; bus8.PENABLE = 0; bus8.PWRITE = 0; bus8.PADDR = '0; bus8.PWDATA = '0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 12'h028; bus.PWDATA = '0;
        #12;
        checks++; if (outPins !== 16'h0) begin failures++; $display("[TB] FAIL reset_out: got %h expected %h", outPins, 16'h0); end
        checks++; if (dirPins !== 16'h0) begin failures++; $display("[TB] FAIL reset_dir: got %h expected %h", dirPins, 16'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_int: got %b expected 0", irq); end
        checks++; if (bus.PSLVERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_pslverr: got %b expected 0", bus.PSLVERR); end
        checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("[TB] FAIL reset_prdata: got %h expected 0", bus.PRDATA); end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = '0;
        @(negedge clk_i);
        rst_n = 1'b1;
        apb_read(12'h00C, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_inten_read: got %h expected 0", rd); end
    endtask

    task automatic test_gpio();
        wr(12'h000, 32'h0000_00FF);
        wr(12'h01C, 32'h0000_0003);
        wr(12'h024, 32'h0000_0001);
        checks++; if (dirPins !== 16'h00FF) begin failures++; $display("[TB] FAIL gpio_dir: got %h expected 00ff", dirPins); end
        checks++; if (outPins !== 16'h0002) begin failures++; $display("[TB] FAIL gpio_out: got %h expected 0002", outPins); end
        apb_read(12'h004, rd, err);
        checks++; if (rd !== 32'h2) begin failures++; $display("[TB] FAIL gpio_out_read: got %h expected 00000002", rd); end
        wr(12'h004, 32'h0000_00F0);
        wr(12'h020, 32'h0000_0030);
        checks++; if (outPins !== 16'h00C0) begin failures++; $display("[TB] FAIL gpio_out_clr: got %h expected 00c0", outPins); end
        apb_read(12'h01C, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL gpio_wo_read: got %h expected 0", rd); end
        wr(12'h000, 32'hFFFF_FFFF);
        apb_read(12'h000, rd, err);
        checks++; if (rd !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL gpio_dir_width: got %h expected 0000ffff", rd); end
        wr(12'h000, 32'h0000_00FF);
    endtask

    task automatic test_in_sync();
        @(negedge clk_i);
        pins = 16'hA5C3;
        apb_read(12'h008, rd, err);
        checks++; if (rd !== 32'h0000_A5C3) begin failures++; $display("[TB] FAIL in_sync: got %h expected 0000a5c3", rd); end
        pins = 16'h0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_edge_irq();
        wr(12'h014, 32'h8);
        wr(12'h010, 32'h8);
        wr(12'h00C, 32'h8);
        @(negedge clk_i);
        pins[3] = 1'b1;
        @(negedge clk_i);
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_early1: got %b expected 0", irq); end
        @(negedge clk_i);
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_early2: got %b expected 0", irq); end
        @(negedge clk_i);
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL edge_rise: got %b expected 1", irq); end
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h8) begin failures++; $display("[TB] FAIL edge_status: got %h expected 8", rd); end
        wr(12'h018, 32'h8);
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_w1c_int: got %b expected 0", irq); end
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL edge_w1c_status: got %h expected 0", rd); end
        pins[3] = 1'b0;
        repeat (3) @(negedge clk_i);
        pins[3] = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL edge_second: got %b expected 1", irq); end
        wr(12'h00C, 32'h0);
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL mask_int: got %b expected 0", irq); end
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h8) begin failures++; $display("[TB] FAIL mask_status_kept: got %h expected 8", rd); end
        wr(12'h018, 32'h8);
        pins[3] = 1'b0;
    endtask

    task automatic test_level();
        wr(12'h010, 32'h0);
        wr(12'h014, 32'h1);
        @(negedge clk_i);
        pins[0] = 1'b1;
        repeat (3) @(negedge clk_i);
        wr(12'h00C, 32'h1);
        repeat (2) @(negedge clk_i);
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL level_int: got %b expected 1", irq); end
        wr(12'h018, 32'h1);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL level_held: got %h expected 1", rd); end
        pins[0] = 1'b0;
        repeat (4) @(negedge clk_i);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL level_latched: got %h expected 1", rd); end
        wr(12'h018, 32'h1);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL level_cleared: got %h expected 0", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL level_int_off: got %b expected 0", irq); end
        wr(12'h00C, 32'h0);
    endtask

    task automatic test_back_to_back_w1c();
        wr(12'h010, 32'h20);
        wr(12'h014, 32'h0);
        @(negedge clk_i);
        pins[5] = 1'b1;
        repeat (4) @(negedge clk_i);
        wr(12'h00C, 32'h20);
        pins[5] = 1'b0;
        repeat (4) @(negedge clk_i);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h20) begin failures++; $display("[TB] FAIL fall_status: got %h expected 20", rd); end
        wr(12'h018, 32'h20);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL fall_w1c: got %h expected 0", rd); end
        pins[5] = 1'b1;
        repeat (4) @(negedge clk_i);
        @(negedge clk_i);
        pins[5] = 1'b0;
        wr(12'h018, 32'h20);
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h20) begin failures++; $display("[TB] FAIL set_beats_clear: got %h expected 20", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL set_beats_clear_int: got %b expected 1", irq); end
        wr(12'h018, 32'h20);
        wr(12'h00C, 32'h0);
    endtask

    task automatic test_errors();
        apb_read(12'h028, rd, err);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_rd_pslverr: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL err_rd_prdata: got %h expected 0", rd); end
        apb_write(12'h002, 32'hFFFF_FFFF, err);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_wr_pslverr: got %b expected 1", err); end
        checks++; if (dirPins !== 16'h00FF) begin failures++; $display("[TB] FAIL err_wr_dir: got %h expected 00ff", dirPins); end
        apb_read(12'h005, rd, err);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL err_misaligned: got err=%b data=%h expected err=1 data=0", err, rd); end
        apb_read(12'h004, rd, err);
        checks++; if (err !== 1'b0 || rd !== 32'hC0) begin failures++; $display("[TB] FAIL ok_read: got err=%b data=%h expected err=0 data=c0", err, rd); end
        apb8_access(1'b1, 12'h000, 32'hFFFF_FFFF, rd);
        apb8_access(1'b0, 12'h000, 32'h0, rd);
        checks++; if (rd !== 32'h0000_00FF) begin failures++; $display("[TB] FAIL pins8_dir: got %h expected 000000ff", rd); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk_i);
        pins[3] = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 12'h004; bus.PWDATA = 32'hA5;
        @(negedge clk_i);
        bus.PENABLE = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (outPins !== 16'h0) begin failures++; $display("[TB] FAIL abort_out_in_reset: got %h expected 0", outPins); end
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL abort_int_in_reset: got %b expected 0", irq); end
        @(negedge clk_i);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL abort_int_after[%0d]: got %b expected 0", i, irq); end
        end
        apb_read(12'h004, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL abort_out_read: got %h expected 0", rd); end
        apb_read(12'h018, rd, err);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL abort_status: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_gpio();
        test_in_sync();
        test_edge_irq();
        test_level();
        test_back_to_back_w1c();
        test_errors();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
